// File: rtl/button_pattern_pkg.sv
// rtl/button_pattern_pkg.sv - shared state type and counter width helper for the pattern sender
package button_pattern_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GAP,
      VERIFY
   } state_t;

   // Width needed to hold values 0..n-1, never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_pattern_sender_if.sv
// rtl/button_pattern_sender_if.sv - handshake and pulse-line bundle for the pattern sender
interface button_pattern_sender_if #(
   parameter int WIDTH = 4
) ();

   logic             start;
   logic [WIDTH-1:0] data;
   logic             abort;
   logic             ready;
   logic             bit_one;
   logic             bit_zero;
   logic             busy;
   logic             verify_strobe;

   modport master (
      output start, data, abort,
      input  ready, bit_one, bit_zero, busy, verify_strobe
   );

   modport slave (
      input  start, data, abort,
      output ready, bit_one, bit_zero, busy, verify_strobe
   );

endinterface

// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - loadable saturating down-counter shared by the pulse and gap phases
module pulse_timer #(
   parameter int TW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          zero
);

   logic [TW-1:0] count;

   // Reload on request, otherwise count down and park at zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - TW'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/button_pattern_sender.sv
// rtl/button_pattern_sender.sv - replays a word MSB first as timed pulses on one/zero lines
module button_pattern_sender
   import button_pattern_pkg::*;
#(
   parameter int WIDTH        = 4,
   parameter int PULSE_CYCLES = 4,
   parameter int GAP_CYCLES   = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   button_pattern_sender_if.slave  bus
);

   localparam int TW = cnt_w(max_of(PULSE_CYCLES, GAP_CYCLES));
   localparam int CW = cnt_w(WIDTH);

   localparam logic [TW-1:0] P_LOAD    = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0] G_LOAD    = TW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    bit_cnt;
   logic             bit_one_q;
   logic             bit_zero_q;
   logic             busy_q;
   logic             verify_q;

   logic             timer_load;
   logic [TW-1:0]    timer_val;
   logic             timer_zero;

   pulse_timer #(.TW(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .zero     (timer_zero)
   );

   // Timer reload happens only on the transitions that enter PULSE or GAP
   always_comb begin
      timer_load = 1'b0;
      timer_val  = '0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               timer_load = 1'b1;
               timer_val  = P_LOAD;
            end
         end
         PULSE: begin
            if (!bus.abort && timer_zero) begin
               timer_load = 1'b1;
               timer_val  = G_LOAD;
            end
         end
         GAP: begin
            if (!bus.abort && timer_zero && bit_cnt != '0) begin
               timer_load = 1'b1;
               timer_val  = P_LOAD;
            end
         end
         default: begin
            timer_load = 1'b0;
         end
      endcase
   end

   // Sequencer with registered pulse lines; abort outranks everything but rst
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         shreg      <= '0;
         bit_cnt    <= '0;
         bit_one_q  <= 1'b0;
         bit_zero_q <= 1'b0;
         busy_q     <= 1'b0;
         verify_q   <= 1'b0;
      end else if (bus.abort && state != IDLE) begin
         state      <= IDLE;
         bit_one_q  <= 1'b0;
         bit_zero_q <= 1'b0;
         busy_q     <= 1'b0;
         verify_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start && !bus.abort) begin
                  shreg      <= bus.data;
                  bit_cnt    <= LAST_BIT;
                  bit_one_q  <= bus.data[WIDTH-1];
                  bit_zero_q <= ~bus.data[WIDTH-1];
                  busy_q     <= 1'b1;
                  state      <= PULSE;
               end
            end
            PULSE: begin
               if (timer_zero) begin
                  shreg      <= shreg << 1;
                  bit_one_q  <= 1'b0;
                  bit_zero_q <= 1'b0;
                  state      <= GAP;
               end
            end
            GAP: begin
               if (timer_zero) begin
                  if (bit_cnt != '0) begin
                     bit_cnt    <= bit_cnt - CW'(1);
                     bit_one_q  <= shreg[WIDTH-1];
                     bit_zero_q <= ~shreg[WIDTH-1];
                     state      <= PULSE;
                  end else begin
                     verify_q <= 1'b1;
                     state    <= VERIFY;
                  end
               end
            end
            VERIFY: begin
               verify_q <= 1'b0;
               busy_q   <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.ready         = (state == IDLE);
   assign bus.bit_one       = bit_one_q;
   assign bus.bit_zero      = bit_zero_q;
   assign bus.busy          = busy_q;
   assign bus.verify_strobe = verify_q;

endmodule

// File: tb/tb_button_pattern_sender.sv
// tb/tb_button_pattern_sender.sv - directed bench with a timing model of the pattern sender
module tb_button_pattern_sender;

   localparam int W = 4;
   localparam int P = 4;
   localparam int G = 4;
   localparam int L = W * (P + G);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   button_pattern_sender_if #(.WIDTH(W)) bus ();

   button_pattern_sender #(
      .WIDTH        (W),
      .PULSE_CYCLES (P),
      .GAP_CYCLES   (G)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int total  = 0;
   int passed = 0;
   int cyc    = 0;
   int acc    = 0;

   // model state: transfer active, word in flight, cycle index since accept
   bit             m_active = 1'b0;
   logic [W-1:0]   m_word   = '0;
   int             m_n      = 0;

   // observation records, cycle numbers relative to the accept edge
   int             pq[$];
   int             tq[$];
   int             vq[$];
   logic [15:0]    rx   = '0;
   int             ones = 0;
   logic           p1   = 1'b0;
   logic           p0   = 1'b0;
   logic [4:0]     e_out;
   logic [4:0]     a_out;
   int             rel;
   int             r;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_active <= 1'b0;
         m_n      <= 0;
      end else if (m_active) begin
         if (bus.abort || m_n == L + 1) m_active <= 1'b0;
         else m_n <= m_n + 1;
      end else if (bus.start && !bus.abort) begin
         m_active <= 1'b1;
         m_word   <= bus.data;
         m_n      <= 1;
      end
   end

   always @(negedge clk) begin
      // expected {ready, busy, bit_one, bit_zero, verify_strobe}
      e_out = 5'b10000;
      if (!rst && m_active) begin
         e_out = 5'b01000;
         if (m_n == L + 1) begin
            e_out[0] = 1'b1;
         end else if ((m_n - 1) % (P + G) < P) begin
            if (m_word[W - 1 - (m_n - 1) / (P + G)]) e_out[2] = 1'b1;
            else e_out[1] = 1'b1;
         end
      end
      a_out = {bus.ready, bus.busy, bus.bit_one, bus.bit_zero, bus.verify_strobe};
      total++;
      if (a_out === e_out) passed++;
      else $display("FAIL outputs t=%0t: got %b expected %b (ready busy one zero verify)",
                    $time, a_out, e_out);

      rel = cyc - acc + 1;
      if (bus.bit_one && !p1) begin
         pq.push_back(rel); tq.push_back(1); rx = {rx[14:0], 1'b1}; ones++;
      end
      if (bus.bit_zero && !p0) begin
         pq.push_back(rel); tq.push_back(0); rx = {rx[14:0], 1'b0};
      end
      if (bus.verify_strobe) vq.push_back(rel);
      p1 = bus.bit_one;
      p0 = bus.bit_zero;
   end

   task automatic clear_rec();
      pq.delete(); tq.delete(); vq.delete();
      rx = '0; ones = 0;
   endtask

   task automatic send(input logic [W-1:0] d);
      @(negedge clk);
      bus.data  = d;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      bus.start = 1'b0;
      clear_rec();
   endtask

   task automatic wait_ready(output int rr);
      rr = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         #1;
         if (bus.ready) begin
            rr = cyc - acc + 1;
            return;
         end
      end
   endtask

   task automatic check_transfer(input string nm, input logic [W-1:0] w, input int rr);
      chk({nm, "_ready_cycle"}, rr, L + 2);
      chk({nm, "_pulse_count"}, pq.size(), W);
      for (int k = 0; k < W; k++) begin
         chk({nm, "_pulse_start"}, qat(pq, k), 1 + k * (P + G));
         chk({nm, "_pulse_kind"}, qat(tq, k), int'(w[W - 1 - k]));
      end
      chk({nm, "_verify_count"}, vq.size(), 1);
      chk({nm, "_verify_cycle"}, qat(vq, 0), L + 1);
      chk({nm, "_rx_word"}, int'(rx[W-1:0]), int'(w));
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      bus.start = 1'b0;
      bus.data  = '0;
      bus.abort = 1'b0;
      rst       = 1'b1;
      repeat (3) @(negedge clk);
      #2;
      chk("reset_ready", int'(bus.ready), 1);
      chk("reset_busy", int'(bus.busy), 0);
      chk("reset_lines", int'({bus.bit_one, bus.bit_zero, bus.verify_strobe}), 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // word 1011 with hand-computed timing
      send(4'b1011);
      wait_ready(r);
      chk("t1_ready_cycle", r, 34);
      chk("t1_start0", qat(pq, 0), 1);
      chk("t1_start1", qat(pq, 1), 9);
      chk("t1_start2", qat(pq, 2), 17);
      chk("t1_start3", qat(pq, 3), 25);
      chk("t1_kind1", qat(tq, 1), 0);
      chk("t1_verify", qat(vq, 0), 33);
      chk("t1_rx", int'(rx[3:0]), 11);
      check_transfer("t1", 4'b1011, r);

      // all-zero word
      repeat (2) @(negedge clk);
      send(4'b0000);
      wait_ready(r);
      check_transfer("t2", 4'b0000, r);
      chk("t2_ones", ones, 0);

      // start and new data while busy are ignored
      repeat (2) @(negedge clk);
      send(4'b0101);
      repeat (5) @(negedge clk);
      bus.start = 1'b1;
      bus.data  = 4'b1111;
      @(negedge clk);
      bus.start = 1'b0;
      wait_ready(r);
      check_transfer("t3", 4'b0101, r);
      chk("t3_ones", ones, 2);

      // abort during the second pulse
      repeat (2) @(negedge clk);
      send(4'b1100);
      repeat (10) @(negedge clk);
      bus.abort = 1'b1;
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      chk("t4_abort_rel", cyc - acc + 1, 11);
      chk("t4_lines_low", int'({bus.bit_one, bus.bit_zero}), 0);
      chk("t4_ready", int'(bus.ready), 1);
      repeat (40) @(negedge clk);
      chk("t4_no_verify", vq.size(), 0);
      chk("t4_pulses", pq.size(), 2);

      // asynchronous reset mid-pulse, then a clean transfer
      send(4'b1000);
      @(negedge clk);
      chk("t5_pulse_before_rst", int'(bus.bit_one), 1);
      #2;
      rst = 1'b1;
      #1;
      chk("t5_lines_drop", int'({bus.bit_one, bus.bit_zero}), 0);
      chk("t5_ready_in_rst", int'(bus.ready), 1);
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b0;
      repeat (40) @(negedge clk);
      chk("t5_no_verify", vq.size(), 0);
      send(4'b0110);
      wait_ready(r);
      check_transfer("t5", 4'b0110, r);

      // start held high across two back-to-back words
      repeat (2) @(negedge clk);
      bus.data  = 4'b1001;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      acc = cyc;
      clear_rec();
      bus.data = 4'b0110;
      repeat (34) @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_ready(r);
      chk("t6_ready_cycle", r, 68);
      chk("t6_pulse_count", pq.size(), 8);
      chk("t6_second_first_pulse", qat(pq, 4), 35);
      chk("t6_second_first_kind", qat(tq, 4), 0);
      chk("t6_verify_count", vq.size(), 2);
      chk("t6_verify0", qat(vq, 0), 33);
      chk("t6_verify1", qat(vq, 1), 67);
      chk("t6_rx", int'(rx[7:0]), int'(8'b10010110));

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
